// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer
//   Command driver for a JK flip-flop. SET/RESET/TOGGLE/HOLD commands are
//   queued in a small FIFO over a valid/ready handshake. Each command drives
//   J/K for max(CMD_LEN,1) cycles, then spends one check cycle with J=K=0
//   and pulses DONE.
//
//   Optional feature (macro JK_CHECK_EN): Q_FB is compared against the
//   predicted flip-flop state in the DONE cycle. A mismatch sets the sticky
//   ERR flag, which ERR_CLR clears (a new mismatch wins over a clear).
//   Without the macro, ERR is tied low and ERR_CLR/Q_FB are ignored.
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   CMD_VALID  command present
//   CMD_READY  FIFO not full (depends only on FIFO occupancy)
//   CMD_OP     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   CMD_LEN    drive length in cycles, 0 treated as 1
//   J, K       registered drive to the flip-flop
//   Q_FB       flip-flop output, synchronous to CLK
//   BUSY       FSM active or FIFO non-empty
//   DONE       one-cycle pulse per completed command
//   ERR        sticky mismatch flag
//   ERR_CLR    synchronous clear of ERR
module jk_drive_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    input  logic             ERR_CLR
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Command FIFO
    logic [1:0]       op_mem_q  [DEPTH];
    logic [LEN_W-1:0] len_mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    op_e              head_op;
    logic [LEN_W-1:0] head_len, len_eff;

    // Sequencer
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d, k_q, k_d, done_q, done_d;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign CMD_READY = !full;
    assign push      = CMD_VALID && !full;
    assign pop       = (state_q == ST_IDLE) && !empty;
    assign head_op   = op_e'(op_mem_q[rd_ptr_q[AW-1:0]]);
    assign head_len  = len_mem_q[rd_ptr_q[AW-1:0]];
    assign len_eff   = (head_len == '0) ? LEN_W'(1) : head_len;

    always_ff @(posedge CLK) begin
        if (push) begin
            op_mem_q[wr_ptr_q[AW-1:0]]  <= CMD_OP;
            len_mem_q[wr_ptr_q[AW-1:0]] <= CMD_LEN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    op_d    = head_op;
                    cnt_d   = len_eff;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                case (op_q)
                    OP_RESET:  begin j_d = 1'b0; k_d = 1'b1; end
                    OP_SET:    begin j_d = 1'b1; k_d = 1'b0; end
                    OP_TOGGLE: begin j_d = 1'b1; k_d = 1'b1; end
                    default:   begin j_d = 1'b0; k_d = 1'b0; end
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    assign J    = j_q;
    assign K    = k_q;
    assign DONE = done_q;
    assign BUSY = (state_q != ST_IDLE) || !empty;

`ifdef JK_CHECK_EN
    logic q_pre_q, q_pre_d, len_lsb_q, len_lsb_d, err_q, err_d, exp_val;

    // J/K are registered, so the flip-flop has seen its last drive edge only
    // in the DONE cycle. The comparison is made there; op_q is still valid
    // because the next pop cannot happen before the following edge.
    always_comb begin
        q_pre_d   = q_pre_q;
        len_lsb_d = len_lsb_q;
        if (pop) begin
            q_pre_d   = Q_FB;
            len_lsb_d = len_eff[0];
        end
        exp_val = q_pre_q;
        case (op_q)
            OP_RESET:  exp_val = 1'b0;
            OP_SET:    exp_val = 1'b1;
            OP_TOGGLE: exp_val = q_pre_q ^ len_lsb_q;
            default:   exp_val = q_pre_q;
        endcase
        err_d = err_q;
        if (ERR_CLR) err_d = 1'b0;
        if (done_q && (Q_FB != exp_val)) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_pre_q   <= 1'b0;
            len_lsb_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            q_pre_q   <= q_pre_d;
            len_lsb_q <= len_lsb_d;
            err_q     <= err_d;
        end
    end

    assign ERR = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{Q_FB, ERR_CLR};
    assign ERR        = 1'b0;
`endif

endmodule
